// File: rtl/comp_mult_op_gen_if.sv
// Operand bus between the stimulus generator and the complex multiplier.
// The checking model taps the same three signals.
interface comp_mult_op_gen_if #(
  parameter int DWIDTH = 8
) ();
  logic                  op_val;
  logic                  op_rdy;
  logic [4*DWIDTH-1:0]   op_data;  // {x1, y1, x2, y2}, two's complement

  modport master (output op_val, output op_data, input op_rdy);
  modport slave  (input  op_val, input  op_data, output op_rdy);
endinterface

// File: rtl/comp_mult_op_gen.sv
// Operand stimulus generator for the complex multiplier.
// Emits num_ops operand sets per burst from a seeded 32-bit Galois LFSR over
// a val/rdy bus; start/busy/done frame each burst.
// Optional macro OP_GEN_CORNER_EN: the first min(4, num_ops) sets of every
// burst come from a fixed corner table (MIN/MAX/zero patterns).
module comp_mult_op_gen #(
  parameter int          DWIDTH    = 8,
  parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_rst,
  input  logic                start,
  input  logic [15:0]         num_ops,
  input  logic [31:0]         seed,
  comp_mult_op_gen_if.master  op_if,
  output logic                busy,
  output logic                done,
  output logic [15:0]         op_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t              r_state, w_next;
  logic [31:0]         r_lfsr;
  logic [15:0]         r_remaining;
  logic [15:0]         r_op_cnt;
  logic                w_hs;
  logic                w_start;
  logic [31:0]         w_lfsr_nxt;
  logic [4*DWIDTH-1:0] w_rand;
  logic [4*DWIDTH-1:0] w_sel;

  assign w_start    = (r_state == S_IDLE) & start;
  // op_val is high exactly in RUN, so the handshake only needs op_rdy there.
  assign w_hs       = (r_state == S_RUN) & op_if.op_rdy;
  assign w_lfsr_nxt = (r_lfsr >> 1) ^ ({32{r_lfsr[0]}} & LFSR_TAPS);
  assign w_rand     = {r_lfsr[24 +: DWIDTH], r_lfsr[16 +: DWIDTH],
                       r_lfsr[8 +: DWIDTH],  r_lfsr[0 +: DWIDTH]};

`ifdef OP_GEN_CORNER_EN
  localparam logic [DWIDTH-1:0] MINV = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [DWIDTH-1:0] MAXV = {1'b0, {(DWIDTH-1){1'b1}}};

  // Corner index saturates at 4; values 0..3 select a table entry.
  logic [2:0]          r_cidx;
  logic                w_corner;
  logic [4*DWIDTH-1:0] w_ctab;

  assign w_corner = ~r_cidx[2];

  // Corner table lookup.
  always_comb begin
    w_ctab = '0;
    case (r_cidx[1:0])
      2'd0:    w_ctab = {MINV, MINV, MINV, MINV};
      2'd1:    w_ctab = {MAXV, MAXV, MAXV, MAXV};
      2'd2:    w_ctab = {MINV, MAXV, MAXV, MINV};
      default: w_ctab = '0;
    endcase
  end

  assign w_sel = w_corner ? w_ctab : w_rand;
`else
  assign w_sel = w_rand;
`endif

  // Data is held at zero outside RUN so the bus reads clean when idle.
  assign op_if.op_val  = (r_state == S_RUN);
  assign op_if.op_data = (r_state == S_RUN) ? w_sel : '0;
  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_FIN);
  assign op_cnt        = r_op_cnt;

  // State register; sw_rst outranks every other input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_state <= S_IDLE;
    else if (sw_rst) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (num_ops == 16'd0) ? S_FIN : S_RUN;
      S_RUN:  if (w_hs && (r_remaining == 16'd1)) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Burst datapath: LFSR, remaining count, handshake count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= 32'h1;
      r_remaining <= '0;
      r_op_cnt    <= '0;
`ifdef OP_GEN_CORNER_EN
      r_cidx      <= '0;
`endif
    end else if (sw_rst) begin
      r_lfsr      <= 32'h1;
      r_remaining <= '0;
      r_op_cnt    <= '0;
`ifdef OP_GEN_CORNER_EN
      r_cidx      <= '0;
`endif
    end else if (w_start) begin
      r_op_cnt <= '0;
      if (num_ops != 16'd0) begin
        // A zero seed would lock the LFSR, so it is promoted to 1.
        r_lfsr      <= (seed == 32'd0) ? 32'h1 : seed;
        r_remaining <= num_ops;
`ifdef OP_GEN_CORNER_EN
        r_cidx      <= '0;
`endif
      end
    end else if (w_hs) begin
      r_op_cnt    <= r_op_cnt + 16'd1;
      r_remaining <= r_remaining - 16'd1;
`ifdef OP_GEN_CORNER_EN
      // LFSR is frozen while corner sets are served so random sets start at the seed.
      if (w_corner) r_cidx <= r_cidx + 3'd1;
      else          r_lfsr <= w_lfsr_nxt;
`else
      r_lfsr <= w_lfsr_nxt;
`endif
    end
  end

endmodule

// File: doc/comp_mult_op_gen.md
Name: comp_mult_op_gen

Overview:
Operand stimulus generator that sits directly upstream of the complex multiplier core. It produces a programmed number of pseudo-random operand sets {x1, y1, x2, y2} from a seeded 32-bit LFSR and drives them over a val-rdy interface. The same op_val/op_rdy/op_data bus is tapped by the checking model. A start/busy/done control interface lets the bench run repeatable bursts.

Parameters:
DWIDTH, 8, operand width in bits. Legal range is 2..8.
LFSR_TAPS, 32'h80200003, Galois right-shift tap mask (x^32+x^22+x^2+x+1).

Ports:
clk        input   1            system clock
rst_n      input   1            hw async reset, active low
sw_rst     input   1            sw sync reset, active high
start      input   1            start-burst pulse
num_ops    input   16           operand sets per burst; sampled on accepted start
seed       input   32           LFSR seed; sampled on accepted start
op_val     output  1            operands valid
op_rdy     input   1            operands ready (from multiplier)
op_data    output  4*DWIDTH     operands {x1, y1, x2, y2}, two's complement
busy       output  1            burst in progress
done       output  1            one-cycle pulse at burst end
op_cnt     output  16           handshakes completed in current/last burst

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (rst_n low, or sw_rst high at a clock edge): state=IDLE, op_val=0, op_data=0, busy=0, done=0, op_cnt=0, lfsr=32'h1, remaining=0.
- sw_rst has priority over every other input. If it arrives mid-burst, the burst aborts with no done pulse.
- FSM states:
  - IDLE: start=1 samples num_ops and seed and clears op_cnt.
    - If num_ops=0: go to FIN.
    - Otherwise: go to RUN, load lfsr = (seed==0) ? 32'h1 : seed, and remaining = num_ops.
  - RUN: op_val=1 and busy=1.
    - Handshake means op_val & op_rdy at a clock edge. On each handshake: op_cnt+1, remaining-1, and lfsr advances one step.
    - On a handshake with remaining==1: go to FIN and drop op_val the next cycle.
  - FIN: done=1 for exactly one cycle, busy=0, then go to IDLE.
- start outside IDLE is ignored.
- Latency: start accepted at edge N gives op_val=1 from cycle N+1, with data from the seed. One operand set per cycle at full throughput when op_rdy is held high.
- LFSR step: next = (lfsr >> 1) ^ ({32{lfsr[0]}} & LFSR_TAPS).
- op_data mapping: x1=lfsr[24+:DWIDTH], y1=lfsr[16+:DWIDTH], x2=lfsr[8+:DWIDTH], y2=lfsr[0+:DWIDTH].
- op_data is combinational from the current lfsr (or the corner table). It stays stable while op_val & ~op_rdy, and changes only after a handshake.
- op_val never drops in RUN without a handshake.
- op_rdy is ignored when op_val=0.
- op_cnt wraps modulo 2^16 and holds its value after done until the next accepted start.
- Back-to-back: a start on the cycle after done (in IDLE) is accepted normally.

Optional Feature:
Macro: OP_GEN_CORNER_EN
- Defined: the first min(4, num_ops) operand sets of each burst come from a fixed corner table instead of the LFSR. MIN = -2^(DWIDTH-1), MAX = 2^(DWIDTH-1)-1.
  - #0 {MIN, MIN, MIN, MIN}
  - #1 {MAX, MAX, MAX, MAX}
  - #2 {MIN, MAX, MAX, MIN}
  - #3 {0, 0, 0, 0}
- The LFSR does not advance during corner sets; random sets then start from the seed. Corner sets count toward num_ops and op_cnt.
- Undefined: every set comes from the LFSR and no corner logic is present.

Test Plan:
- Basic burst: DWIDTH=8, seed=32'h1, num_ops=2, op_rdy=1 -> op_data 32'h00000001 then 32'h80200003; done pulses 1 cycle after the 2nd handshake; op_cnt=2.
- Backpressure: same stimulus, op_rdy low for 5 cycles after op_val rises -> op_data holds 32'h00000001 for all 5 cycles; the 2nd value appears only after the handshake.
- num_ops=0 with start -> no op_val; done pulses at N+1; op_cnt=0; busy never set.
- Abort: start with num_ops=100, sw_rst at handshake 10 -> op_val=0 next cycle; no done; op_cnt=0. A restart with seed=1 reproduces 32'h00000001.
- seed=0 behaves identically to seed=1; start while busy is ignored (num_ops unchanged, op_cnt continues).
- OP_GEN_CORNER_EN defined, DWIDTH=8, seed=1, num_ops=6 -> 32'h80808080, 32'h7F7F7F7F, 32'h807F7F80, 32'h00000000, 32'h00000001, 32'h80200003.
